// File: rtl/decode_buffered_pkg.sv
// Shared RV32I decode types: opcode map, control word, instruction-buffer entry,
// and the combinational control ROM used by the decode stage.
package decode_buffered_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_word   pc;
        rv32i_word   instr;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        rv32i_word   i_imm;
        rv32i_word   s_imm;
        rv32i_word   b_imm;
        rv32i_word   u_imm;
        rv32i_word   j_imm;
        logic        regwrite;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } rv32i_control_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } ibuf_entry_t;

    localparam rv32i_word DEFAULT_NOP_INSTR = 32'h0000_0013;

    function automatic logic opcode_valid(input logic [6:0] op);
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg, op_csr: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Pure field extraction; callers substitute the NOP word for illegal opcodes.
    function automatic rv32i_control_word control_rom(input rv32i_word pc, input rv32i_word instr);
        rv32i_control_word cw;
        cw           = '0;
        cw.pc        = pc;
        cw.instr     = instr;
        cw.opcode    = rv32i_opcode'(instr[6:0]);
        cw.funct3    = instr[14:12];
        cw.funct7    = instr[31:25];
        cw.rd        = instr[11:7];
        cw.rs1       = instr[19:15];
        cw.rs2       = instr[24:20];
        cw.i_imm     = {{21{instr[31]}}, instr[30:20]};
        cw.s_imm     = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        cw.b_imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        cw.u_imm     = {instr[31:12], 12'h000};
        cw.j_imm     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        case (instr[6:0])
            op_lui, op_auipc, op_jal, op_jalr,
            op_load, op_imm, op_reg, op_csr: cw.regwrite = 1'b1;
            default:                         cw.regwrite = 1'b0;
        endcase
        cw.mem_read  = (instr[6:0] == op_load);
        cw.mem_write = (instr[6:0] == op_store);
        cw.branch    = (instr[6:0] == op_br);
        cw.jump      = (instr[6:0] == op_jal) || (instr[6:0] == op_jalr);
        return cw;
    endfunction

endpackage

// File: rtl/decode_buffered_ibuf_fifo.sv
// Instruction queue between fetch and decode: DEPTH entries (power of two),
// wrapping pointers, occupancy count, synchronous clear for pipeline flush.
module ibuf_fifo
    import decode_buffered_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  ibuf_entry_t            push_data,
    input  logic                   pop,
    output ibuf_entry_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    ibuf_entry_t   mem [DEPTH];
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && rst_n && !clear) mem[tail_ptr] <= push_data;
    end

    assign head  = mem[head_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/decode_buffered.sv
// Buffered RV32I decode stage: queues fetched (pc, instr) pairs and presents a
// registered control word to execute, with stall, flush, bypass and illegal handling.
module decode_buffered
    import decode_buffered_pkg::*;
#(
    parameter int        DEPTH     = 4,
    parameter bit        BYPASS    = 1'b1,
    parameter rv32i_word NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  rv32i_word              if_pc,
    input  rv32i_word              if_instr,
    output logic                   id_valid,
    input  logic                   id_ready,
    output rv32i_control_word      ctrl,
    output logic                   id_illegal,
    output logic [$clog2(DEPTH):0] occupancy
);

    ibuf_entry_t            head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;

    logic              enq;
    logic              load;
    logic              take_fifo;
    logic              take_bypass;
    logic              fifo_push;
    rv32i_word         sel_pc;
    rv32i_word         sel_instr;
    logic              sel_valid;
    logic              sel_legal;
    rv32i_control_word ctrl_next;

    // Registered full flag only, so execute's ready never reaches fetch combinationally.
    assign if_ready  = !full;
    assign occupancy = count;

    always_comb begin
        enq         = if_valid && if_ready && !flush;
        load        = (!id_valid || id_ready) && !flush;
        take_fifo   = load && !empty;
        take_bypass = BYPASS && load && empty && enq;
        fifo_push   = enq && !take_bypass;

        sel_pc    = '0;
        sel_instr = NOP_INSTR;
        sel_valid = 1'b0;
        if (take_fifo) begin
            sel_pc    = head.pc;
            sel_instr = head.instr;
            sel_valid = 1'b1;
        end else if (take_bypass) begin
            sel_pc    = if_pc;
            sel_instr = if_instr;
            sel_valid = 1'b1;
        end

        sel_legal = opcode_valid(sel_instr[6:0]);
        ctrl_next = control_rom(sel_pc, sel_legal ? sel_instr : NOP_INSTR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            id_valid   <= 1'b0;
            id_illegal <= 1'b0;
            ctrl       <= control_rom('0, NOP_INSTR);
        end else if (load) begin
            id_valid   <= sel_valid;
            id_illegal <= sel_valid && !sel_legal;
            ctrl       <= ctrl_next;
        end
    end

    ibuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (fifo_push),
        .push_data ('{pc: if_pc, instr: if_instr}),
        .pop       (take_fifo),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule
